// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory stage of the 5-stage RV32I pipeline.
//
// Takes the execute-stage result (ALU result as effective address, rs2 as
// store data), performs LB/LH/LW/LBU/LHU/SB/SH/SW against an internal
// little-endian data memory, picks the write-back value and registers it
// into the M/W pipeline register. Latency is exactly one cycle, no stalls.
//
// Ports
//   clock          in   1   rising-edge clock
//   reset          in   1   synchronous active-high reset (memory untouched)
//   e_valid        in   1   execute stage holds a real instruction
//   e_opcode       in   7   instruction opcode
//   e_funct3       in   3   access size / signedness for loads and stores
//   e_rd           in   5   destination register
//   e_pc           in   32  instruction PC
//   e_alu_res      in   32  ALU result / effective address
//   e_data_rs2     in   32  store data
//   w_valid        out  1   registered e_valid
//   w_pc           out  32  registered PC
//   w_rd           out  5   registered destination register
//   w_data         out  32  registered write-back value
//   w_write_enable out  1   register-file write enable for w_rd
//   w_fault        out  1   misaligned / illegal / out-of-range access
//   m_load_count   out  32  completed loads (wraps)
//   m_store_count  out  32  committed stores (wraps)
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int          MEM_BYTES = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [6:0]  e_opcode,
  input  logic [2:0]  e_funct3,
  input  logic [4:0]  e_rd,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_alu_res,
  input  logic [31:0] e_data_rs2,
  output logic        w_valid,
  output logic [31:0] w_pc,
  output logic [4:0]  w_rd,
  output logic [31:0] w_data,
  output logic        w_write_enable,
  output logic        w_fault,
  output logic [31:0] m_load_count,
  output logic [31:0] m_store_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  localparam int ADDR_W = $clog2(MEM_BYTES);
  localparam int WORDS  = MEM_BYTES / 4;
  localparam int IDX_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  // Word-organised storage with per-byte write enables; every legal access
  // is naturally aligned, so it never straddles two words.
  logic [31:0] r_mem [WORDS];

  logic        r_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_rd;
  logic [31:0] r_data;
  logic        r_we;
  logic        r_fault;
  logic [31:0] r_load_count;
  logic [31:0] r_store_count;

  logic        w_is_load;
  logic        w_is_store;
  logic [31:0] w_offset;
  logic [2:0]  w_size;
  logic [32:0] w_end;
  logic        w_in_range;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_fault_next;
  logic        w_store_ok;
  logic [IDX_W-1:0] w_word_idx;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rd_word;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [31:0] w_data_next;
  logic        w_we_next;
  logic        w_wb_opcode;

  assign w_is_load  = (e_opcode == OP_LOAD);
  assign w_is_store = (e_opcode == OP_STORE);

  // Offset wraps modulo 2^32, so addresses below the base become huge and
  // fail the range test naturally.
  assign w_offset = e_alu_res - BASE_ADDR;

  always_comb begin
    w_size = 3'd4;
    case (e_funct3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
  end

  // One extra bit so offset + size cannot overflow the comparison.
  assign w_end      = {1'b0, w_offset} + {30'd0, w_size};
  assign w_in_range = (w_end <= 33'(MEM_BYTES));

  assign w_misaligned = ((e_funct3[1:0] == 2'b01) && e_alu_res[0]) ||
                        ((e_funct3[1:0] == 2'b10) && (e_alu_res[1:0] != 2'b00));

  assign w_illegal = (w_is_load  && ((e_funct3 == 3'd3) || (e_funct3 == 3'd6) || (e_funct3 == 3'd7))) ||
                     (w_is_store && (e_funct3 >= 3'd3));

  assign w_fault_next = e_valid && (w_is_load || w_is_store) &&
                        (w_misaligned || w_illegal || !w_in_range);

  assign w_store_ok = e_valid && w_is_store && !w_fault_next && !reset;

  assign w_word_idx = IDX_W'(w_offset >> 2);

  // Replicate store data across lanes; the byte enable picks the live lane(s).
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = e_data_rs2;
    case (e_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_offset[1:0];
        w_wdata = {4{e_data_rs2[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_offset[1:0];
        w_wdata = {2{e_data_rs2[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = e_data_rs2;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_word_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // Load path reads the array as it stands before this edge's write.
  assign w_rd_word = r_mem[w_word_idx];
  assign w_shifted = w_rd_word >> {w_offset[1:0], 3'b000};

  always_comb begin
    w_load_data = 32'd0;
    if (!w_fault_next) begin
      case (e_funct3)
        3'd0:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
        3'd1:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
        3'd2:    w_load_data = w_shifted;
        3'd4:    w_load_data = {24'd0, w_shifted[7:0]};
        3'd5:    w_load_data = {16'd0, w_shifted[15:0]};
        default: w_load_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    w_data_next = e_alu_res;
    if (w_is_load) begin
      w_data_next = w_load_data;
    end else if ((e_opcode == OP_JAL) || (e_opcode == OP_JALR)) begin
      w_data_next = e_pc + 32'd4;
    end
  end

  assign w_wb_opcode = (e_opcode == OP_LUI)  || (e_opcode == OP_AUIPC) ||
                       (e_opcode == OP_JAL)  || (e_opcode == OP_JALR)  ||
                       (e_opcode == OP_OP)   || (e_opcode == OP_OPIMM) ||
                       (e_opcode == OP_LOAD);

  assign w_we_next = e_valid && !w_fault_next && (e_rd != 5'd0) && w_wb_opcode;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_pc          <= 32'd0;
      r_rd          <= 5'd0;
      r_data        <= 32'd0;
      r_we          <= 1'b0;
      r_fault       <= 1'b0;
      r_load_count  <= 32'd0;
      r_store_count <= 32'd0;
    end else begin
      r_valid <= e_valid;
      r_pc    <= e_pc;
      r_rd    <= e_rd;
      r_data  <= w_data_next;
      r_we    <= w_we_next;
      r_fault <= w_fault_next;
      if (e_valid && w_is_load && !w_fault_next) begin
        r_load_count <= r_load_count + 32'd1;
      end
      if (w_store_ok) begin
        r_store_count <= r_store_count + 32'd1;
      end
    end
  end

  assign w_valid        = r_valid;
  assign w_pc           = r_pc;
  assign w_rd           = r_rd;
  assign w_data         = r_data;
  assign w_write_enable = r_we;
  assign w_fault        = r_fault;
  assign m_load_count   = r_load_count;
  assign m_store_count  = r_store_count;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed scoreboard bench for mem_stage.
// The driver issues one instruction per cycle and queues the hand-computed
// M/W result; a monitor pops and compares one entry after every rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  logic        clock = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [6:0]  e_opcode;
  logic [2:0]  e_funct3;
  logic [4:0]  e_rd;
  logic [31:0] e_pc;
  logic [31:0] e_alu_res;
  logic [31:0] e_data_rs2;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic        w_write_enable;
  logic        w_fault;
  logic [31:0] m_load_count;
  logic [31:0] m_store_count;

  always #5 clock = ~clock;

  mem_stage dut (
    .clock          (clock),
    .reset          (reset),
    .e_valid        (e_valid),
    .e_opcode       (e_opcode),
    .e_funct3       (e_funct3),
    .e_rd           (e_rd),
    .e_pc           (e_pc),
    .e_alu_res      (e_alu_res),
    .e_data_rs2     (e_data_rs2),
    .w_valid        (w_valid),
    .w_pc           (w_pc),
    .w_rd           (w_rd),
    .w_data         (w_data),
    .w_write_enable (w_write_enable),
    .w_fault        (w_fault),
    .m_load_count   (m_load_count),
    .m_store_count  (m_store_count)
  );

  typedef struct {
    string       name;
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        flt;
    logic [31:0] lc;
    logic [31:0] sc;
    bit          chk_meta;
    bit          chk_data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_lc = 32'd0;
  logic [31:0] model_sc = 32'd0;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s got=%08h expected=%08h", nm, fld, got, exp);
    end
  endtask

  // Monitor: one queued result per rising edge, sampled 1 time unit later.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk(e.name, "w_valid", {31'd0, w_valid}, {31'd0, e.vld});
        chk(e.name, "w_write_enable", {31'd0, w_write_enable}, {31'd0, e.we});
        chk(e.name, "w_fault", {31'd0, w_fault}, {31'd0, e.flt});
        chk(e.name, "m_load_count", m_load_count, e.lc);
        chk(e.name, "m_store_count", m_store_count, e.sc);
        if (e.chk_meta) begin
          chk(e.name, "w_pc", w_pc, e.pc);
          chk(e.name, "w_rd", {27'd0, w_rd}, {27'd0, e.rd});
        end
        if (e.chk_data) begin
          chk(e.name, "w_data", w_data, e.data);
        end
        $display("txn %-14s valid=%0b rd=%0d data=%08h we=%0b fault=%0b loads=%0d stores=%0d",
                 e.name, w_valid, w_rd, w_data, w_write_enable, w_fault, m_load_count, m_store_count);
      end
    end
  end

  // Drive one instruction (called at a falling edge), queue its expected
  // result, then wait for the next falling edge.
  task automatic issue(input string nm, input logic rst, input logic vld,
                       input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] exp_data, input logic exp_we, input logic exp_flt,
                       input bit chk_data);
    exp_t e;
    reset      = rst;
    e_valid    = vld;
    e_opcode   = op;
    e_funct3   = f3;
    e_rd       = rd;
    e_pc       = pc;
    e_alu_res  = addr;
    e_data_rs2 = rs2;
    if (rst) begin
      model_lc = 32'd0;
      model_sc = 32'd0;
    end else if (vld && !exp_flt) begin
      if (op == LOAD)  model_lc = model_lc + 32'd1;
      if (op == STORE) model_sc = model_sc + 32'd1;
    end
    e.name     = nm;
    e.vld      = rst ? 1'b0 : vld;
    e.pc       = rst ? 32'd0 : pc;
    e.rd       = rst ? 5'd0 : rd;
    e.data     = rst ? 32'd0 : exp_data;
    e.we       = rst ? 1'b0 : exp_we;
    e.flt      = rst ? 1'b0 : exp_flt;
    e.lc       = model_lc;
    e.sc       = model_sc;
    e.chk_meta = rst || vld;
    e.chk_data = rst || chk_data;
    sb_q.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; e_valid = 1'b0; e_opcode = 7'd0; e_funct3 = 3'd0; e_rd = 5'd0;
    e_pc = 32'd0; e_alu_res = 32'd0; e_data_rs2 = 32'd0;
    @(negedge clock);
    //    name            rst vld op     f3  rd  pc            addr          rs2           exp_data      we  flt chk
    issue("reset0",       1, 0, LOAD,  3'd2, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0,  0,  1);
    issue("reset1",       1, 0, LOAD,  3'd2, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0,  0,  1);
    issue("sw_deadbeef",  0, 1, STORE, 3'd2, 0, 32'h100,      32'h01000010, 32'hDEADBEEF, 32'h01000010, 0,  0,  1);
    issue("lb_13",        0, 1, LOAD,  3'd0, 5, 32'h104,      32'h01000013, 32'h0,        32'hFFFFFFDE, 1,  0,  1);
    issue("lbu_13",       0, 1, LOAD,  3'd4, 6, 32'h108,      32'h01000013, 32'h0,        32'h000000DE, 1,  0,  1);
    issue("lh_10",        0, 1, LOAD,  3'd1, 7, 32'h10C,      32'h01000010, 32'h0,        32'hFFFFBEEF, 1,  0,  1);
    issue("lhu_12",       0, 1, LOAD,  3'd5, 8, 32'h110,      32'h01000012, 32'h0,        32'h0000DEAD, 1,  0,  1);
    issue("sb_7f",        0, 1, STORE, 3'd0, 0, 32'h114,      32'h01000011, 32'h1234567F, 32'h01000011, 0,  0,  1);
    issue("lw_after_sb",  0, 1, LOAD,  3'd2, 9, 32'h118,      32'h01000010, 32'h0,        32'hDEAD7FEF, 1,  0,  1);
    issue("sh_misalign",  0, 1, STORE, 3'd1, 0, 32'h11C,      32'h01000011, 32'hAAAA5555, 32'h01000011, 0,  1,  1);
    issue("lw_misalign",  0, 1, LOAD,  3'd2, 9, 32'h120,      32'h01000012, 32'h0,        32'h0,        0,  1,  1);
    issue("lw_nowrite",   0, 1, LOAD,  3'd2, 9, 32'h124,      32'h01000010, 32'h0,        32'hDEAD7FEF, 1,  0,  1);
    issue("sw_in_reset",  1, 1, STORE, 3'd2, 0, 32'h128,      32'h01000010, 32'h11223344, 32'h0,        0,  0,  1);
    issue("lw_post_rst",  0, 1, LOAD,  3'd2, 10, 32'h12C,     32'h01000010, 32'h0,        32'hDEAD7FEF, 1,  0,  1);
    issue("jal_rd1",      0, 1, JAL,   3'd0, 1, 32'h01000020, 32'h12345678, 32'h0,        32'h01000024, 1,  0,  1);
    issue("jalr_wrap",    0, 1, JALR,  3'd0, 2, 32'hFFFFFFFC, 32'h00000010, 32'h0,        32'h00000000, 1,  0,  1);
    issue("addi_rd0",     0, 1, OPIMM, 3'd0, 0, 32'h130,      32'h00000055, 32'h0,        32'h00000055, 0,  0,  1);
    issue("addi_rd3",     0, 1, OPIMM, 3'd0, 3, 32'h134,      32'h000000AA, 32'h0,        32'h000000AA, 1,  0,  1);
    issue("lw_below",     0, 1, LOAD,  3'd2, 4, 32'h138,      32'h00FFFFFC, 32'h0,        32'h0,        0,  1,  1);
    issue("sw_top",       0, 1, STORE, 3'd2, 0, 32'h13C,      32'h010FFFFC, 32'hCAFEF00D, 32'h010FFFFC, 0,  0,  1);
    issue("lw_top",       0, 1, LOAD,  3'd2, 11, 32'h140,     32'h010FFFFC, 32'h0,        32'hCAFEF00D, 1,  0,  1);
    issue("lh_top",       0, 1, LOAD,  3'd1, 12, 32'h144,     32'h010FFFFE, 32'h0,        32'hFFFFCAFE, 1,  0,  1);
    issue("lw_past_end",  0, 1, LOAD,  3'd2, 13, 32'h148,     32'h01100000, 32'h0,        32'h0,        0,  1,  1);
    issue("ld_f3_3",      0, 1, LOAD,  3'd3, 14, 32'h14C,     32'h01000010, 32'h0,        32'h0,        0,  1,  1);
    issue("st_f3_3",      0, 1, STORE, 3'd3, 0, 32'h150,      32'h01000010, 32'h99999999, 32'h01000010, 0,  1,  1);
    issue("lw_after_ill", 0, 1, LOAD,  3'd2, 15, 32'h154,     32'h01000010, 32'h0,        32'hDEAD7FEF, 1,  0,  1);
    issue("branch",       0, 1, BRANCH,3'd0, 4, 32'h158,      32'h00000001, 32'h0,        32'h00000001, 0,  0,  1);
    issue("bubble_sw",    0, 0, STORE, 3'd2, 0, 32'h15C,      32'h01000010, 32'h0BADF00D, 32'h0,        0,  0,  0);
    issue("lw_after_bub", 0, 1, LOAD,  3'd2, 16, 32'h160,     32'h01000010, 32'h0,        32'hDEAD7FEF, 1,  0,  1);

    // Load counter wrap: preload the counter to all-ones, then one more load.
    force dut.r_load_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_load_count;
    model_lc = 32'hFFFF_FFFF;
    issue("lw_wrap",      0, 1, LOAD,  3'd2, 17, 32'h164,     32'h010FFFFC, 32'h0,        32'hCAFEF00D, 1,  0,  1);

    e_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clock);
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
